// File: rtl/irq_flag_ctrl.sv
// irq_flag_ctrl -- single-level interrupt controller placed upstream of the
// C/Z flag register.
//
// On entry it snapshots the live C/Z flags and the resume PC and redirects
// the core to a per-line vector. On return-from-interrupt it drives the flag
// register's interrupt write port for one cycle so the saved flags are
// restored.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clock_en        state advances only on enabled edges
//   irq_i           rising-edge triggered requests (N_IRQ)
//   irq_mask_i      per-line enable, 1 = enabled
//   gie_i           global interrupt enable
//   boundary_i      core at an instruction boundary
//   reti_i          return-from-interrupt decoded
//   pc_i            resume PC
//   c_i, z_i        live flags from the flag register
//   int_take_o      redirect the core to vector_o (ENTER)
//   vector_o        handler address (ENTER only, else 0)
//   ret_pc_o        saved PC
//   ack_o           one-hot acknowledge (ENTER)
//   iwe_o, intc_o, intz_o  flag-register restore port (EXIT)
//   in_isr_o        handler active
module irq_flag_ctrl #(
    parameter int          N_IRQ      = 4,
    parameter int          PC_W       = 8,
    parameter int unsigned VEC_BASE   = 32'hF0,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clock_en,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             gie_i,
    input  logic             boundary_i,
    input  logic             reti_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             c_i,
    input  logic             z_i,
    output logic             int_take_o,
    output logic [PC_W-1:0]  vector_o,
    output logic [PC_W-1:0]  ret_pc_o,
    output logic [N_IRQ-1:0] ack_o,
    output logic             iwe_o,
    output logic             intc_o,
    output logic             intz_o,
    output logic             in_isr_o
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_ISR, S_EXIT} state_t;

    state_t             r_state;
    logic [N_IRQ-1:0]   r_pend;
    logic [N_IRQ-1:0]   r_irq_prev;
    logic [IDX_W-1:0]   r_idx;
    logic               r_saved_c;
    logic               r_saved_z;
    logic [PC_W-1:0]    r_saved_pc;

    logic               r_int_take;
    logic [PC_W-1:0]    r_vector;
    logic [N_IRQ-1:0]   r_ack;
    logic               r_iwe;
    logic               r_intc;
    logic               r_intz;
    logic               r_in_isr;

    logic [N_IRQ-1:0]   w_rise;
    logic [N_IRQ-1:0]   w_clr;
    logic [N_IRQ-1:0]   w_elig;
    logic               w_any;
    logic [IDX_W-1:0]   w_win_idx;
    logic [N_IRQ-1:0]   w_win_ack;
    logic [PC_W-1:0]    w_win_vec;

    assign w_rise = irq_i & ~r_irq_prev;
    // The line being acknowledged is retired at the end of ENTER; a fresh
    // edge on the same line in that cycle still wins (set over clear).
    assign w_clr  = (r_state == S_ENTER) ? (N_IRQ'(1) << r_idx) : '0;
    assign w_elig = r_pend & irq_mask_i;
    assign w_any  = |w_elig;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_win_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) w_win_idx = IDX_W'(i);
        end
    end

    assign w_win_ack = N_IRQ'(1) << w_win_idx;
    assign w_win_vec = PC_W'(VEC_BASE + 32'(w_win_idx) * VEC_STRIDE);

    // Outputs are registered alongside the state so they are pure functions
    // of the state just entered; gating the whole block on clock_en is what
    // stretches ENTER/EXIT pulses across disabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_irq_prev <= '0;
            r_idx      <= '0;
            r_saved_c  <= 1'b0;
            r_saved_z  <= 1'b0;
            r_saved_pc <= '0;
            r_int_take <= 1'b0;
            r_vector   <= '0;
            r_ack      <= '0;
            r_iwe      <= 1'b0;
            r_intc     <= 1'b0;
            r_intz     <= 1'b0;
            r_in_isr   <= 1'b0;
        end else if (clock_en) begin
            r_irq_prev <= irq_i;
            r_pend     <= (r_pend & ~w_clr) | w_rise;
            case (r_state)
                S_IDLE: begin
                    if (gie_i && boundary_i && w_any) begin
                        r_state    <= S_ENTER;
                        r_idx      <= w_win_idx;
                        r_saved_c  <= c_i;
                        r_saved_z  <= z_i;
                        r_saved_pc <= pc_i;
                        r_int_take <= 1'b1;
                        r_vector   <= w_win_vec;
                        r_ack      <= w_win_ack;
                    end
                end
                S_ENTER: begin
                    r_state    <= S_ISR;
                    r_int_take <= 1'b0;
                    r_vector   <= '0;
                    r_ack      <= '0;
                    r_in_isr   <= 1'b1;
                end
                S_ISR: begin
                    // No nesting: pend keeps accumulating, gie_i is ignored.
                    if (reti_i) begin
                        r_state  <= S_EXIT;
                        r_in_isr <= 1'b0;
                        r_iwe    <= 1'b1;
                        r_intc   <= r_saved_c;
                        r_intz   <= r_saved_z;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_iwe   <= 1'b0;
                    r_intc  <= 1'b0;
                    r_intz  <= 1'b0;
                end
            endcase
        end
    end

    assign int_take_o = r_int_take;
    assign vector_o   = r_vector;
    assign ret_pc_o   = r_saved_pc;
    assign ack_o      = r_ack;
    assign iwe_o      = r_iwe;
    assign intc_o     = r_intc;
    assign intz_o     = r_intz;
    assign in_isr_o   = r_in_isr;

endmodule

// File: tb/tb_irq_flag_ctrl.sv
// Scoreboard bench for irq_flag_ctrl: stimulus pushes expected ENTER/EXIT
// events, a negedge monitor pops and compares on each rising int_take_o or
// iwe_o. Directed checks cover reset, latency, back-to-back and gating.
module tb_irq_flag_ctrl;

    typedef struct {
        bit         is_exit;
        logic [7:0] vec;
        logic [3:0] ack;
        logic [7:0] pc;
        logic       c;
        logic       z;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clock_en = 1'b1;
    logic [3:0] irq_i = 4'h0;
    logic [3:0] irq_mask_i = 4'hF;
    logic       gie_i = 1'b0;
    logic       boundary_i = 1'b1;
    logic       reti_i = 1'b0;
    logic [7:0] pc_i = 8'h00;
    logic       c_i = 1'b0;
    logic       z_i = 1'b0;
    logic       int_take_o;
    logic [7:0] vector_o;
    logic [7:0] ret_pc_o;
    logic [3:0] ack_o;
    logic       iwe_o;
    logic       intc_o;
    logic       intz_o;
    logic       in_isr_o;

    int  n_vec = 0;
    int  n_err = 0;
    int  take_len = 0;
    int  last_take_len = 0;
    ev_t exp_q[$];

    irq_flag_ctrl dut (
        .clk(clk), .rst(rst), .clock_en(clock_en), .irq_i(irq_i),
        .irq_mask_i(irq_mask_i), .gie_i(gie_i), .boundary_i(boundary_i),
        .reti_i(reti_i), .pc_i(pc_i), .c_i(c_i), .z_i(z_i),
        .int_take_o(int_take_o), .vector_o(vector_o), .ret_pc_o(ret_pc_o),
        .ack_o(ack_o), .iwe_o(iwe_o), .intc_o(intc_o), .intz_o(intz_o),
        .in_isr_o(in_isr_o)
    );

    always #5 clk = ~clk;

    // Monitor
    initial begin : monitor
        logic prev_take, prev_iwe;
        ev_t  e;
        prev_take = 1'b0;
        prev_iwe  = 1'b0;
        forever begin
            @(negedge clk);
            if (int_take_o) take_len++;
            else if (take_len != 0) begin
                last_take_len = take_len;
                take_len = 0;
            end
            if ((int_take_o && !prev_take) || (iwe_o && !prev_iwe)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: take=%0b iwe=%0b vec=%h ack=%b, required no event",
                             int_take_o, iwe_o, vector_o, ack_o);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_exit) begin
                        if (!(int_take_o && {vector_o, ack_o, ret_pc_o} === {e.vec, e.ack, e.pc})) begin
                            n_err++;
                            $display("FAIL entry: take=%0b vec=%h ack=%b ret_pc=%h, required take=1 vec=%h ack=%b ret_pc=%h",
                                     int_take_o, vector_o, ack_o, ret_pc_o, e.vec, e.ack, e.pc);
                        end
                    end else begin
                        if (!(iwe_o && {intc_o, intz_o} === {e.c, e.z})) begin
                            n_err++;
                            $display("FAIL exit: iwe=%0b intc=%0b intz=%0b, required iwe=1 intc=%0b intz=%0b",
                                     iwe_o, intc_o, intz_o, e.c, e.z);
                        end
                    end
                end
            end
            prev_take = int_take_o;
            prev_iwe  = iwe_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_entry(input logic [7:0] vec, input logic [3:0] ack, input logic [7:0] pc);
        ev_t e;
        e.is_exit = 1'b0; e.vec = vec; e.ack = ack; e.pc = pc; e.c = 1'b0; e.z = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_exit(input logic c, input logic z);
        ev_t e;
        e.is_exit = 1'b1; e.vec = 8'h00; e.ack = 4'h0; e.pc = 8'h00; e.c = c; e.z = z;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] bits);
        irq_i = irq_i | bits;
        tick(1);
        irq_i = irq_i & ~bits;
    endtask

    // Bounded wait for in_isr_o; returns aligned just after a posedge.
    task automatic wait_isr(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (in_isr_o) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: in_isr_o=0 after 20 cycles, required 1", name);
        end
        tick(1);
    endtask

    task automatic do_reti();
        reti_i = 1'b1;
        tick(1);
        reti_i = 1'b0;
        tick(3);
    endtask

    initial begin
        // Reset with all lines high: outputs stay 0.
        irq_i = 4'hF;
        tick(3);
        @(negedge clk);
        check("reset_outputs", {int_take_o, vector_o, ret_pc_o, ack_o, iwe_o, intc_o, intz_o, in_isr_o}, 0);
        irq_i = 4'h0;
        gie_i = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(5);
        check("post_reset_idle", {int_take_o, in_isr_o}, 0);

        // Single IRQ on line 2, with latency check.
        pc_i = 8'h3A; c_i = 1'b1; z_i = 1'b0;
        push_entry(8'hF8, 4'b0100, 8'h3A);
        pulse(4'b0100);
        @(negedge clk);
        check("latency_capture", int_take_o, 0);
        @(negedge clk);
        check("latency_take", int_take_o, 1);
        tick(1);
        wait_isr("single_isr");
        c_i = 1'b0; z_i = 1'b1;
        push_exit(1'b1, 1'b0);
        do_reti();
        check("single_done", {in_isr_o, iwe_o}, 0);

        // Priority and back-to-back without a new edge.
        pc_i = 8'h55; c_i = 1'b0; z_i = 1'b1;
        push_entry(8'hF4, 4'b0010, 8'h55);
        pulse(4'b1010);
        wait_isr("prio_isr");
        c_i = 1'b1; z_i = 1'b1;
        push_exit(1'b0, 1'b1);
        push_entry(8'hFC, 4'b1000, 8'h55);
        reti_i = 1'b1;
        tick(1);
        reti_i = 1'b0;
        tick(2);
        @(negedge clk);
        check("back_to_back_take", int_take_o, 1);
        wait_isr("b2b_isr");
        push_exit(1'b1, 1'b1);
        do_reti();

        // Masked line latches and fires once unmasked.
        pc_i = 8'h20; c_i = 1'b0; z_i = 1'b0;
        irq_mask_i = 4'b1110;
        pulse(4'b0001);
        tick(4);
        check("masked_no_entry", {int_take_o, in_isr_o}, 0);
        push_entry(8'hF0, 4'b0001, 8'h20);
        irq_mask_i = 4'hF;
        wait_isr("unmask_isr");
        push_exit(1'b0, 1'b0);
        do_reti();

        // gie and boundary gating.
        pc_i = 8'h21; c_i = 1'b1; z_i = 1'b1;
        gie_i = 1'b0;
        pulse(4'b0001);
        tick(4);
        check("gie_off_no_entry", {int_take_o, in_isr_o}, 0);
        gie_i = 1'b1; boundary_i = 1'b0;
        tick(4);
        check("boundary_off_no_entry", {int_take_o, in_isr_o}, 0);
        push_entry(8'hF0, 4'b0001, 8'h21);
        boundary_i = 1'b1;
        wait_isr("gated_isr");
        push_exit(1'b1, 1'b1);
        do_reti();

        // clock_en low for 3 edges during ENTER stretches the pulse to 4 cycles.
        pc_i = 8'h30; c_i = 1'b1; z_i = 1'b0;
        push_entry(8'hF8, 4'b0100, 8'h30);
        pulse(4'b0100);
        tick(1);
        clock_en = 1'b0;
        tick(3);
        check("ce_hold_take", int_take_o, 1);
        clock_en = 1'b1;
        tick(1);
        @(negedge clk);
        check("ce_take_len", last_take_len, 4);
        check("ce_in_isr", in_isr_o, 1);
        push_exit(1'b1, 0);
        do_reti();

        // Reset while in the handler: in_isr drops at once, no EXIT pulse.
        pc_i = 8'h40;
        push_entry(8'hF4, 4'b0010, 8'h40);
        pulse(4'b0010);
        wait_isr("rst_isr");
        rst = 1'b0;
        #1;
        check("rst_mid_isr", {in_isr_o, iwe_o}, 0);
        tick(2);
        rst = 1'b1;
        reti_i = 1'b1;
        tick(1);
        reti_i = 1'b0;
        tick(5);
        check("rst_no_exit", {iwe_o, in_isr_o, ret_pc_o}, 0);

        // Every expected event must have been observed.
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: exit=%0b vec=%h never observed, required observed", e.is_exit, e.vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation reached 200000, required earlier finish");
        $fatal(1, "timeout");
    end

endmodule
